// File: rtl/alu_regfile_datapath_pkg.sv
// Shared types for the execute-stage slice: ALU op classes, ALU operations,
// operand-select encodings and the RV32I ABI register names.
package alu_regfile_datapath_pkg;

  typedef logic flag_t;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_TYPE_R = 2'b10,
    ALUOP_TYPE_I = 2'b11
  } aluOp_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_operation_t;

  localparam logic [1:0] SRC1_REG  = 2'd0;
  localparam logic [1:0] SRC1_IMMU = 2'd1;
  localparam logic [1:0] SRC1_FOUR = 2'd2;
  localparam logic [1:0] SRC1_ZERO = 2'd3;

  localparam logic [1:0] SRC2_REG  = 2'd0;
  localparam logic [1:0] SRC2_IMMI = 2'd1;
  localparam logic [1:0] SRC2_IMMS = 2'd2;
  localparam logic [1:0] SRC2_PC   = 2'd3;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

endpackage

package reg_names;

  typedef enum logic [4:0] {
    REG_ZERO, REG_RA, REG_SP, REG_GP, REG_TP, REG_T0, REG_T1, REG_T2,
    REG_S0, REG_S1, REG_A0, REG_A1, REG_A2, REG_A3, REG_A4, REG_A5,
    REG_A6, REG_A7, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
    REG_S8, REG_S9, REG_S10, REG_S11, REG_T3, REG_T4, REG_T5, REG_T6
  } regName_t;

endpackage

// File: rtl/alu_regfile_datapath_alu.sv
// 32-bit integer ALU with signed-overflow and zero flags; fully combinational.
module alu_regfile_datapath_alu
  import alu_regfile_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] bus_a_i,
  input  logic [DATA_WIDTH-1:0] bus_b_i,
  input  alu_operation_t        op_sel_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output flag_t                 overflow_o,
  output flag_t                 zero_o
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] sum, diff;
  logic [4:0]            shamt;

  assign sum   = bus_a_i + bus_b_i;
  assign diff  = bus_a_i - bus_b_i;
  assign shamt = bus_b_i[4:0];

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    unique case (op_sel_i)
      ALU_ADD: begin
        result_o   = sum;
        overflow_o = (bus_a_i[MSB] == bus_b_i[MSB]) && (sum[MSB] != bus_a_i[MSB]);
      end
      ALU_SUB: begin
        result_o   = diff;
        overflow_o = (bus_a_i[MSB] != bus_b_i[MSB]) && (diff[MSB] != bus_a_i[MSB]);
      end
      ALU_SLL:  result_o = bus_a_i << shamt;
      ALU_SRL:  result_o = bus_a_i >> shamt;
      ALU_SRA:  result_o = DATA_WIDTH'($signed(bus_a_i) >>> shamt);
      ALU_SLT:  result_o = {{(DATA_WIDTH-1){1'b0}}, $signed(bus_a_i) < $signed(bus_b_i)};
      ALU_SLTU: result_o = {{(DATA_WIDTH-1){1'b0}}, bus_a_i < bus_b_i};
      ALU_XOR:  result_o = bus_a_i ^ bus_b_i;
      ALU_OR:   result_o = bus_a_i | bus_b_i;
      ALU_AND:  result_o = bus_a_i & bus_b_i;
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_regfile_datapath_ctrl.sv
// ALU control decoder: maps op class plus funct3/funct7 to an ALU operation.
// Illegal funct combinations flag error and fall back to ADD.
module alu_regfile_datapath_ctrl
  import alu_regfile_datapath_pkg::*;
(
  input  aluOp_t         alu_op_i,
  input  logic [2:0]     funct3_i,
  input  logic [6:0]     funct7_i,
  output alu_operation_t op_sel_o,
  output flag_t          error_o
);

  always_comb begin
    op_sel_o = ALU_ADD;
    error_o  = 1'b0;
    unique case (alu_op_i)
      ALUOP_MEM:    op_sel_o = ALU_ADD;
      ALUOP_BRANCH: op_sel_o = ALU_SUB;
      ALUOP_TYPE_R: begin
        if (funct7_i == FUNCT7_BASE) begin
          unique case (funct3_i)
            3'd0: op_sel_o = ALU_ADD;
            3'd1: op_sel_o = ALU_SLL;
            3'd2: op_sel_o = ALU_SLT;
            3'd3: op_sel_o = ALU_SLTU;
            3'd4: op_sel_o = ALU_XOR;
            3'd5: op_sel_o = ALU_SRL;
            3'd6: op_sel_o = ALU_OR;
            default: op_sel_o = ALU_AND;
          endcase
        end else if (funct7_i == FUNCT7_ALT && funct3_i == 3'd0) begin
          op_sel_o = ALU_SUB;
        end else if (funct7_i == FUNCT7_ALT && funct3_i == 3'd5) begin
          op_sel_o = ALU_SRA;
        end else begin
          error_o = 1'b1;
        end
      end
      default: begin
        // Immediate forms ignore funct7 except for the shift encodings.
        unique case (funct3_i)
          3'd0: op_sel_o = ALU_ADD;
          3'd1: begin
            if (funct7_i == FUNCT7_BASE) op_sel_o = ALU_SLL;
            else                         error_o  = 1'b1;
          end
          3'd2: op_sel_o = ALU_SLT;
          3'd3: op_sel_o = ALU_SLTU;
          3'd4: op_sel_o = ALU_XOR;
          3'd5: begin
            if (funct7_i == FUNCT7_BASE)     op_sel_o = ALU_SRL;
            else if (funct7_i == FUNCT7_ALT) op_sel_o = ALU_SRA;
            else                             error_o  = 1'b1;
          end
          3'd6: op_sel_o = ALU_OR;
          default: op_sel_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_regfile_datapath_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// x0 is hardwired to zero; there is no write-to-read bypass.
module alu_regfile_datapath_regfile #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  wen_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [4:0]            rd_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o
);

  logic [DATA_WIDTH-1:0] regs_q [32];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wen_i && (rd_i != 5'd0)) begin
      regs_q[rd_i] <= data_i;
    end
  end

  // Entry 0 is only ever cleared, so reading it directly yields zero.
  assign rdata_a_o = regs_q[rs1_i];
  assign rdata_b_o = regs_q[rs2_i];

endmodule

// File: rtl/alu_regfile_datapath.sv
// Execute-stage slice: register file, ALU control decoder, ALU and operand muxes.
// Reads and ALU result are combinational; only register writes are clocked.
module alu_regfile_datapath
  import alu_regfile_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  wen,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [4:0]            rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            aluOp,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [1:0]            aluSrc1,
  input  logic [1:0]            aluSrc2,
  input  logic [DATA_WIDTH-1:0] immU,
  input  logic [DATA_WIDTH-1:0] immI,
  input  logic [DATA_WIDTH-1:0] immS,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] regA_out,
  output logic [DATA_WIDTH-1:0] regB_out,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  overflow,
  output logic                  Z,
  output logic                  error
);

  logic [DATA_WIDTH-1:0] bus_a, bus_b;
  alu_operation_t        op_sel;

  alu_regfile_datapath_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk       (clk),
    .rstN      (rstN),
    .wen_i     (wen),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .rd_i      (rd),
    .data_i    (data_in),
    .rdata_a_o (regA_out),
    .rdata_b_o (regB_out)
  );

  alu_regfile_datapath_ctrl u_ctrl (
    .alu_op_i (aluOp_t'(aluOp)),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .op_sel_o (op_sel),
    .error_o  (error)
  );

  always_comb begin
    unique case (aluSrc1)
      SRC1_REG:  bus_a = regA_out;
      SRC1_IMMU: bus_a = immU;
      SRC1_FOUR: bus_a = DATA_WIDTH'(4);
      default:   bus_a = '0;
    endcase
  end

  always_comb begin
    unique case (aluSrc2)
      SRC2_REG:  bus_b = regB_out;
      SRC2_IMMI: bus_b = immI;
      SRC2_IMMS: bus_b = immS;
      default:   bus_b = pc;
    endcase
  end

  alu_regfile_datapath_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .bus_a_i    (bus_a),
    .bus_b_i    (bus_b),
    .op_sel_i   (op_sel),
    .result_o   (alu_out),
    .overflow_o (overflow),
    .zero_o     (Z)
  );

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed bench: a vector table loaded into x1/x2 and checked per entry,
// followed by hand-written register-file and reset sequences.
module tb_alu_regfile_datapath;
  import reg_names::*;

  logic        clk = 1'b0;
  logic        rstN, wen;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] data_in, immU, immI, immS, pc;
  logic [1:0]  aluOp, aluSrc1, aluSrc2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] regA_out, regB_out, alu_out;
  logic        overflow, Z, error;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_regfile_datapath #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rstN(rstN), .wen(wen), .rs1(rs1), .rs2(rs2), .rd(rd),
    .data_in(data_in), .aluOp(aluOp), .funct3(funct3), .funct7(funct7),
    .aluSrc1(aluSrc1), .aluSrc2(aluSrc2), .immU(immU), .immI(immI),
    .immS(immS), .pc(pc), .regA_out(regA_out), .regB_out(regB_out),
    .alu_out(alu_out), .overflow(overflow), .Z(Z), .error(error)
  );

  typedef struct {
    string       name;
    logic [31:0] x1, x2;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  s1, s2;
    logic [31:0] immu, immi, imms, pcv;
    logic [31:0] exp;
    logic        z, ovf, err;
  } vec_t;

  localparam logic [1:0] MEM = 2'b00, BR = 2'b01, TR = 2'b10, TI = 2'b11;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [31:0] x1, logic [31:0] x2,
                              logic [1:0] op, logic [2:0] f3, logic [6:0] f7,
                              logic [1:0] s1, logic [1:0] s2, logic [31:0] immu,
                              logic [31:0] immi, logic [31:0] imms, logic [31:0] pcv,
                              logic [31:0] exp, logic z, logic ovf, logic err);
    vec_t v;
    v.name = name; v.x1 = x1; v.x2 = x2; v.op = op; v.f3 = f3; v.f7 = f7;
    v.s1 = s1; v.s2 = s2; v.immu = immu; v.immi = immi; v.imms = imms; v.pcv = pcv;
    v.exp = exp; v.z = z; v.ovf = ovf; v.err = err;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(logic [4:0] addr, logic [31:0] val);
    @(negedge clk);
    wen = 1'b1; rd = addr; data_in = val;
    @(posedge clk);
    #1 wen = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; wen = 1'b0; rs1 = '0; rs2 = '0; rd = '0; data_in = '0;
    aluOp = TR; funct3 = '0; funct7 = '0; aluSrc1 = '0; aluSrc2 = '0;
    immU = '0; immI = '0; immS = '0; pc = '0;

    //        name        x1            x2            op  f3 f7     s1 s2 immU          immI          immS          pc            exp           z  ov er
    vecs.push_back(mk("add",      32'h5,        32'h3,        TR, 0, 7'h00, 0, 0, 0,            0,            0,            0,            32'h8,        0, 0, 0));
    vecs.push_back(mk("sub_zero", 32'h7,        32'h7,        TR, 0, 7'h20, 0, 0, 0,            0,            0,            0,            32'h0,        1, 0, 0));
    vecs.push_back(mk("sub_ovf",  32'h80000000, 32'h1,        TR, 0, 7'h20, 0, 0, 0,            0,            0,            0,            32'h7FFFFFFF, 0, 1, 0));
    vecs.push_back(mk("sub_ovf2", 32'h7FFFFFFF, 32'hFFFFFFFF, TR, 0, 7'h20, 0, 0, 0,            0,            0,            0,            32'h80000000, 0, 1, 0));
    vecs.push_back(mk("add_ovf",  32'h7FFFFFFF, 32'h1,        TR, 0, 7'h00, 0, 0, 0,            0,            0,            0,            32'h80000000, 0, 1, 0));
    vecs.push_back(mk("srl",      32'hF0000000, 32'h4,        TR, 5, 7'h00, 0, 0, 0,            0,            0,            0,            32'h0F000000, 0, 0, 0));
    vecs.push_back(mk("sra",      32'hF0000000, 32'h4,        TR, 5, 7'h20, 0, 0, 0,            0,            0,            0,            32'hFF000000, 0, 0, 0));
    vecs.push_back(mk("sll_zero", 32'hF0000000, 32'h4,        TR, 1, 7'h00, 0, 0, 0,            0,            0,            0,            32'h00000000, 1, 0, 0));
    vecs.push_back(mk("sra_31",   32'h80000000, 32'h1F,       TR, 5, 7'h20, 0, 0, 0,            0,            0,            0,            32'hFFFFFFFF, 0, 0, 0));
    vecs.push_back(mk("slt",      32'hFFFFFFFF, 32'h1,        TR, 2, 7'h00, 0, 0, 0,            0,            0,            0,            32'h1,        0, 0, 0));
    vecs.push_back(mk("sltu",     32'hFFFFFFFF, 32'h1,        TR, 3, 7'h00, 0, 0, 0,            0,            0,            0,            32'h0,        1, 0, 0));
    vecs.push_back(mk("xor",      32'hF0F0F0F0, 32'hFF00FF00, TR, 4, 7'h00, 0, 0, 0,            0,            0,            0,            32'h0FF00FF0, 0, 0, 0));
    vecs.push_back(mk("or",       32'hF0F0F0F0, 32'hFF00FF00, TR, 6, 7'h00, 0, 0, 0,            0,            0,            0,            32'hFFF0FFF0, 0, 0, 0));
    vecs.push_back(mk("and",      32'hF0F0F0F0, 32'hFF00FF00, TR, 7, 7'h00, 0, 0, 0,            0,            0,            0,            32'hF000F000, 0, 0, 0));
    vecs.push_back(mk("addi",     32'hFFFFFFFF, 32'h1,        TI, 0, 7'h00, 0, 1, 0,            32'hFFFFFFFF, 0,            0,            32'hFFFFFFFE, 0, 0, 0));
    vecs.push_back(mk("r_illegal",32'hFFFFFFFF, 32'h1,        TR, 4, 7'h20, 0, 0, 0,            0,            0,            0,            32'h0,        1, 0, 1));
    vecs.push_back(mk("slli_bad", 32'h5,        32'h3,        TI, 1, 7'h20, 0, 1, 0,            32'h2,        0,            0,            32'h7,        0, 0, 1));
    vecs.push_back(mk("srai",     32'hF0000000, 32'h0,        TI, 5, 7'h20, 0, 1, 0,            32'h404,      0,            0,            32'hFF000000, 0, 0, 0));
    vecs.push_back(mk("xori_f7",  32'h0000FFFF, 32'h0,        TI, 4, 7'h7F, 0, 1, 0,            32'hFFFFFFFF, 0,            0,            32'hFFFF0000, 0, 0, 0));
    vecs.push_back(mk("branch",   32'h5,        32'h5,        BR, 3, 7'h55, 0, 0, 0,            0,            0,            0,            32'h0,        1, 0, 0));
    vecs.push_back(mk("mem_immS", 32'h5,        32'h5,        MEM,0, 7'h00, 3, 2, 0,            0,            32'h100,      0,            32'h100,      0, 0, 0));
    vecs.push_back(mk("auipc",    32'h5,        32'h5,        MEM,0, 7'h00, 1, 3, 32'h12345000, 0,            0,            32'h80,       32'h12345080, 0, 0, 0));
    vecs.push_back(mk("pc_plus4", 32'h5,        32'h5,        MEM,0, 7'h00, 2, 3, 0,            0,            0,            32'h1000,     32'h1004,     0, 0, 0));

    // Reset state: registers clear while rstN is held low.
    rs1 = 5'd5; rs2 = 5'd31;
    #12;
    chk("reset_regA", regA_out, 32'h0);
    chk("reset_regB", regB_out, 32'h0);
    // A write attempted during reset must not land.
    wr(5'd4, 32'h1234);
    rs1 = 5'd4;
    #1 chk("write_in_reset", regA_out, 32'h0);
    @(negedge clk); rstN = 1'b1;

    foreach (vecs[i]) begin
      wr(REG_RA, vecs[i].x1);
      wr(REG_SP, vecs[i].x2);
      rs1 = REG_RA; rs2 = REG_SP;
      aluOp = vecs[i].op; funct3 = vecs[i].f3; funct7 = vecs[i].f7;
      aluSrc1 = vecs[i].s1; aluSrc2 = vecs[i].s2;
      immU = vecs[i].immu; immI = vecs[i].immi; immS = vecs[i].imms; pc = vecs[i].pcv;
      #2;
      chk({vecs[i].name, "_regA"}, regA_out, vecs[i].x1);
      chk({vecs[i].name, "_regB"}, regB_out, vecs[i].x2);
      chk({vecs[i].name, "_alu"},  alu_out,  vecs[i].exp);
      chk({vecs[i].name, "_Z"},    {31'b0, Z},        {31'b0, vecs[i].z});
      chk({vecs[i].name, "_ovf"},  {31'b0, overflow}, {31'b0, vecs[i].ovf});
      chk({vecs[i].name, "_err"},  {31'b0, error},    {31'b0, vecs[i].err});
    end

    // x0 ignores writes and keeps reading zero.
    wr(REG_ZERO, 32'hDEADBEEF);
    rs1 = REG_ZERO; rs2 = REG_ZERO;
    aluOp = TR; funct3 = 3'd0; funct7 = 7'h00; aluSrc1 = 2'd0; aluSrc2 = 2'd0;
    #1;
    chk("x0_regA", regA_out, 32'h0);
    chk("x0_alu_Z", {31'b0, Z}, 32'h1);

    // No bypass: the new value appears only after the write edge.
    rs1 = REG_T0;
    @(negedge clk);
    wen = 1'b1; rd = REG_T0; data_in = 32'hABCD0123;
    #1 chk("nobypass_before", regA_out, 32'h0);
    @(posedge clk);
    #1 wen = 1'b0;
    chk("nobypass_after", regA_out, 32'hABCD0123);

    // Mid-cycle reset clears the file without waiting for a clock edge.
    rs1 = REG_RA; rs2 = REG_T0;
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    chk("async_rst_regA", regA_out, 32'h0);
    chk("async_rst_regB", regB_out, 32'h0);
    @(negedge clk); rstN = 1'b1;
    wr(REG_T0, 32'h55);
    #1 chk("post_rst_write", regB_out, 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_regfile_datapath.md
Name: alu_regfile_datapath

Overview:
Execute-stage datapath slice of the RV32I core. It combines a 32-entry register file, an ALU control decoder and a 32-bit integer ALU with operand-select muxes. Register reads are combinational. The write port is synchronous and is fed externally through data_in. The ALU result is combinational from the register outputs, immediates and control.

Parameters:
DATA_WIDTH, 32, register and ALU datapath width (only 32 is supported)

Ports:
clk  in  1  clock; all register writes occur on the rising edge
rstN  in  1  reset; one clock, asynchronous active-low reset clearing the register file
wen  in  1  register write enable
rs1  in  5  read address A
rs2  in  5  read address B
rd  in  5  write address
data_in  in  32  write data
aluOp  in  2  ALU op class (aluOp_t)
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
aluSrc1  in  2  operand A select
aluSrc2  in  2  operand B select
immU, immI, immS, pc  in  32 each  extended immediates and PC
regA_out  out  32  contents of register rs1
regB_out  out  32  contents of register rs2
alu_out  out  32  ALU result
overflow  out  1  signed overflow flag
Z  out  1  zero flag
error  out  1  illegal funct combination

Behaviour:
- Register file
  - 32 x 32-bit registers.
  - rstN low clears all registers to 0 asynchronously.
  - On the rising clk edge with wen=1 and rd!=0, the register at rd is loaded with data_in.
  - Writes to x0 are ignored; x0 always reads 0.
  - Reads are combinational with no write-to-read bypass: a same-cycle write is visible on regA_out/regB_out after the edge.
- Operand mux A (aluSrc1): 0 selects regA_out, 1 selects immU, 2 selects constant 4, 3 selects 0.
- Operand mux B (aluSrc2): 0 selects regB_out, 1 selects immI, 2 selects immS, 3 selects pc.
- aluOp encoding: MEM=00, BRANCH=01, TYPE_R=10, TYPE_I=11.
- Decoder output opSel (alu_operation_t, 4 bits) takes one of: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - MEM gives ADD.
  - BRANCH gives SUB.
  - TYPE_R, funct7=0: funct3 0..7 map to ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - TYPE_R, funct7=0x20: funct3=0 gives SUB, funct3=5 gives SRA.
  - TYPE_I: funct3 gives the same mapping with funct7 ignored, except funct3=1 requires funct7=0 and funct3=5 uses funct7 0/0x20 to choose SRL/SRA.
  - Any other combination gives error=1 and opSel=ADD; otherwise error=0.
  - The decoder is purely combinational.
- ALU (combinational)
  - ADD/SUB: two's-complement modulo 2^32.
  - SLL/SRL/SRA: shift amount is bus_b[4:0]; SRA sign-fills.
  - SLT: signed less-than; SLTU: unsigned less-than. Result is 1 or 0, zero-extended.
  - XOR/OR/AND: bitwise.
  - overflow: for ADD it is 1 when both operands share a sign and the result sign differs. For SUB it is 1 when the operand signs differ and the result sign differs from bus_a. For all other operations it is 0.
  - Z is 1 exactly when alu_out equals 0.
- Reset has no effect on the combinational outputs other than through cleared register contents.
- A write during reset is ignored.

Decomposition:
- Package definitions: aluOp_t, alu_operation_t, flag_t (1-bit logic), operand-select constants.
- Package reg_names: regName_t enum for x0..x31 with ABI names.
- The top instantiates three sub-modules: the register file, the ALU control decoder and the ALU. Operand muxes live in the top.

Test Plan:
1. Reset, then write x1=0x5 and x2=0x3, set rs1=1, rs2=2, aluSrc1=0, aluSrc2=0, aluOp=TYPE_R, funct7=0, funct3=0 -> alu_out=0x8, Z=0, overflow=0, error=0.
2. Same setup with funct7=0x20 and x1=x2=7 -> SUB, alu_out=0, Z=1. Then x1=0x80000000, x2=1 -> alu_out=0x7FFFFFFF, overflow=1.
3. Write x0=0xDEADBEEF with wen=1, then read rs1=0 -> regA_out=0.
4. x1=0xF0000000, x2=4: SRL -> 0x0F000000; SRA -> 0xFF000000; SLL -> 0x00000000 with Z=1.
5. x1=0xFFFFFFFF, x2=1: SLT -> 1, SLTU -> 0. TYPE_I, aluSrc2=1, immI=0xFFFFFFFF, funct3=0 -> alu_out=0xFFFFFFFE.
6. TYPE_R with funct7=0x20 and funct3=4 -> error=1, opSel=ADD. Assert rstN low mid-run -> all registers read 0 immediately.
